// File: rtl/axi_lite_write_master.sv
// AXI4-Lite single-beat write initiator: takes one command at a time, drives AW and W
// independently, waits for B and reports the captured response as a one-cycle pulse.
module axi_lite_write_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_data,
   input  logic [DATA_WIDTH/8-1:0] cmd_strb,
   input  logic [2:0]              cmd_prot,
   output logic [ADDR_WIDTH-1:0]   AWADDR,
   output logic [2:0]              AWPROT,
   output logic                    AWVALID,
   input  logic                    AWREADY,
   output logic [DATA_WIDTH-1:0]   WDATA,
   output logic [DATA_WIDTH/8-1:0] WSTRB,
   output logic                    WVALID,
   input  logic                    WREADY,
   input  logic [1:0]              BRESP,
   input  logic                    BVALID,
   output logic                    BREADY,
   output logic                    rsp_valid,
   output logic [1:0]              rsp_resp,
   output logic                    busy
);

   typedef enum logic [1:0] {IDLE, ADDR_DATA, WAIT_B, RESP} state_t;

   state_t state, state_nxt;
   logic   init_q;
   logic   aw_done, w_done;
   logic   cmd_hs, aw_hs, w_hs, b_hs;

   // init_q keeps cmd_ready low until the first edge after reset release
   assign cmd_ready = init_q && (state == IDLE);
   assign BREADY    = (state == WAIT_B);
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

   assign cmd_hs = cmd_valid & cmd_ready;
   assign aw_hs  = AWVALID & AWREADY;
   assign w_hs   = WVALID & WREADY;
   assign b_hs   = BVALID & BREADY;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (cmd_hs) state_nxt = ADDR_DATA;
         // same-cycle handshakes count as done so AW/W can finish in any order
         ADDR_DATA: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WAIT_B;
         WAIT_B:    if (b_hs) state_nxt = RESP;
         RESP:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // channel payloads are held only while VALID is high, zero otherwise
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         init_q   <= 1'b0;
         AWVALID  <= 1'b0;
         AWADDR   <= '0;
         AWPROT   <= '0;
         WVALID   <= 1'b0;
         WDATA    <= '0;
         WSTRB    <= '0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
         rsp_resp <= '0;
      end else begin
         init_q <= 1'b1;
         if (cmd_hs) begin
            AWVALID <= 1'b1;
            AWADDR  <= cmd_addr;
            AWPROT  <= cmd_prot;
            WVALID  <= 1'b1;
            WDATA   <= cmd_data;
            WSTRB   <= cmd_strb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end else begin
            if (aw_hs) begin
               AWVALID <= 1'b0;
               AWADDR  <= '0;
               AWPROT  <= '0;
               aw_done <= 1'b1;
            end
            if (w_hs) begin
               WVALID <= 1'b0;
               WDATA  <= '0;
               WSTRB  <= '0;
               w_done <= 1'b1;
            end
            if (state == RESP) begin
               aw_done <= 1'b0;
               w_done  <= 1'b0;
            end
         end
         if (b_hs) rsp_resp <= BRESP;
      end
   end

endmodule

// File: doc/axi_lite_write_master.md
AXI_LITE_WRITE_MASTER -- requirements
Module: axi_lite_write_master

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 32: width of AWADDR and cmd_addr.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32 (32 or 64 only): width of WDATA and cmd_data; strobe width is DATA_WIDTH/8.
REQ-003 The module SHALL have port ACLK  input  1  clock; all logic on the rising edge.
REQ-004 The module SHALL have port ARESETn  input  1  reset; asynchronous, active-low.
REQ-005 The module SHALL have port cmd_valid  input  1  a write command is offered.
REQ-006 The module SHALL have port cmd_ready  output  1  the command is accepted in this cycle if cmd_valid=1.
REQ-007 The module SHALL have ports cmd_addr  input  ADDR_WIDTH; cmd_data  input  DATA_WIDTH; cmd_strb  input  DATA_WIDTH/8; cmd_prot  input  3: the command payload.
REQ-008 The module SHALL have ports AWADDR  output  ADDR_WIDTH; AWPROT  output  3; AWVALID  output  1; AWREADY  input  1: the write address channel, initiator side.
REQ-009 The module SHALL have ports WDATA  output  DATA_WIDTH; WSTRB  output  DATA_WIDTH/8; WVALID  output  1; WREADY  input  1: the write data channel.
REQ-010 The module SHALL have ports BRESP  input  2; BVALID  input  1; BREADY  output  1: the write response channel.
REQ-011 The module SHALL have ports rsp_valid  output  1 (one-cycle pulse: transaction complete) and rsp_resp  output  2 (captured BRESP).
REQ-012 The module SHALL have port busy  output  1, high in every state except IDLE.

Function
REQ-013 The FSM SHALL have four states: IDLE, ADDR_DATA, WAIT_B and RESP.
REQ-014 cmd_ready SHALL be 1 only in IDLE; a handshake (cmd_valid & cmd_ready) SHALL register addr/data/strb/prot and move the FSM to ADDR_DATA.
REQ-015 On entry to ADDR_DATA, AWVALID and WVALID SHALL both be 1 in the first cycle after acceptance; the AW and W channels SHALL be handled independently.
REQ-016 AWVALID SHALL stay high until the first cycle with AWREADY=1; it SHALL drop on the next edge and set the internal flag aw_done.
REQ-017 WVALID SHALL behave in the same way with WREADY and w_done.
REQ-018 AW and W handshakes SHALL complete in either order or in the same cycle.
REQ-019 AWADDR, AWPROT, WDATA and WSTRB SHALL stay stable while their VALID is high.
REQ-020 VALID SHALL never be withdrawn before READY.
REQ-021 AWADDR, AWPROT, WDATA and WSTRB SHALL be 0 whenever their VALID is 0.
REQ-022 When aw_done and w_done are both set (including via same-cycle handshakes), the FSM SHALL move to WAIT_B; BREADY SHALL be 1 only in WAIT_B.
REQ-023 BVALID arriving before WAIT_B SHALL be ignored: it SHALL not be acknowledged and the FSM state SHALL not change.
REQ-024 In WAIT_B, BVALID & BREADY SHALL capture BRESP into rsp_resp and move the FSM to RESP.
REQ-025 In RESP, rsp_valid SHALL be 1 for exactly one cycle; the FSM SHALL then return to IDLE and clear aw_done and w_done.
REQ-026 rsp_resp SHALL hold its value until the next B handshake.
REQ-027 Minimum latency SHALL be: accept at edge N; AW/W valid in cycle N+1; with READY high, BREADY in N+2; BVALID in N+2 gives rsp_valid in N+3 and cmd_ready in N+4.
REQ-028 There SHALL be no outstanding-transaction limit above 1 and no timeout; the FSM SHALL wait in any state indefinitely.
REQ-029 BRESP values SLVERR (2) and DECERR (3) SHALL be reported unchanged and SHALL not cause a retry.

Reset
REQ-030 ARESETn=0 SHALL immediately, without a clock, force: FSM to IDLE; AWVALID, WVALID, BREADY, rsp_valid and busy to 0; AWADDR, AWPROT, WDATA, WSTRB and rsp_resp to 0; aw_done and w_done cleared.
REQ-031 cmd_ready SHALL be 0 while ARESETn=0 and 1 from the first edge after deassertion.
REQ-032 Reset mid-transaction SHALL abandon the transaction with no rsp_valid.

Verification
REQ-033 Bench SHALL cover the basic write: cmd addr=0x0000_0010, data=0xDEAD_BEEF, strb=0xF; AWREADY, WREADY and BVALID tied 1, BRESP=0 -> AWADDR=0x10 and WDATA=0xDEADBEEF in cycle N+1; rsp_valid in N+3; rsp_resp=0.
REQ-034 Bench SHALL cover AW before W: AWREADY=1 and WREADY held 0 for 3 cycles -> AWVALID drops after 1 cycle; WVALID stays high 4 cycles with WDATA stable; BREADY rises only after the W handshake.
REQ-035 Bench SHALL cover W before AW: WREADY=1 and AWREADY delayed 5 cycles -> BREADY=0 throughout; early BVALID is not acknowledged; completes after the AW handshake.
REQ-036 Bench SHALL cover the error response: BRESP=2 -> rsp_resp=2 with a single rsp_valid pulse; rsp_resp still reads 2 in the next IDLE.
REQ-037 Bench SHALL cover back-to-back commands: cmd_valid held high with 2 commands -> the second is accepted exactly when cmd_ready returns (N+4 minimum), with no overlap of VALIDs.
REQ-038 Bench SHALL cover reset mid-operation: ARESETn=0 while AWVALID=1 -> AWVALID=0 before the next edge; no rsp_valid; cmd_ready=1 on the first edge after release.
